// File: rtl/exe_stage_pipe.sv
// Execute stage of the 5-stage ARM pipeline: forwarding muxes, Val2 shifter,
// ALU with NZCV status register, branch-target adder and the EXE/MEM register.
module exe_stage_pipe #(
   parameter int DW = 32,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic [3:0]    exe_cmd,
   input  logic          wb_en_in,
   input  logic          mem_r_en_in,
   input  logic          mem_w_en_in,
   input  logic          s_in,
   input  logic          b_in,
   input  logic          imm,
   input  logic [11:0]   shift_operand,
   input  logic [23:0]   signed_imm_24,
   input  logic [DW-1:0] pc_in,
   input  logic [DW-1:0] val_Rn,
   input  logic [DW-1:0] val_Rm,
   input  logic [RW-1:0] dest_in,
   input  logic [1:0]    sel_src1,
   input  logic [1:0]    sel_src2,
   input  logic [DW-1:0] fwd_mem_val,
   input  logic [DW-1:0] fwd_wb_val,
   output logic          wb_en,
   output logic          mem_r_en,
   output logic          mem_w_en,
   output logic [DW-1:0] alu_result,
   output logic [DW-1:0] val_Rm_out,
   output logic [RW-1:0] dest,
   output logic [3:0]    status,
   output logic          branch_taken,
   output logic [DW-1:0] branch_address
);

   // Handshake: freeze is the inverse of the memory stage's ready. While it is
   // high nothing registered here may change; the same instruction is re-presented
   // on the inputs and is accepted on the first edge where freeze is low.

   logic [DW-1:0] op1;
   logic [DW-1:0] rm_f;
   logic [DW-1:0] val2;
   logic [4:0]    rot_amt;
   logic [4:0]    sh_amt;
   logic [2*DW-1:0] rot_tmp;
   logic [DW-1:0] imm8_ext;

   always_comb begin
      case (sel_src1)
         2'd1:    op1 = fwd_mem_val;
         2'd2:    op1 = fwd_wb_val;
         default: op1 = val_Rn;
      endcase
      case (sel_src2)
         2'd1:    rm_f = fwd_mem_val;
         2'd2:    rm_f = fwd_wb_val;
         default: rm_f = val_Rm;
      endcase
   end

   // Rotates use a doubled word so that an amount of 0 passes the value through.
   always_comb begin
      rot_amt  = {shift_operand[11:8], 1'b0};
      sh_amt   = shift_operand[11:7];
      imm8_ext = {{(DW-8){1'b0}}, shift_operand[7:0]};
      rot_tmp  = '0;
      val2     = '0;
      if (imm) begin
         rot_tmp = {imm8_ext, imm8_ext} >> rot_amt;
         val2    = rot_tmp[DW-1:0];
      end else if (mem_r_en_in || mem_w_en_in) begin
         val2 = {{(DW-12){1'b0}}, shift_operand};
      end else begin
         case (shift_operand[6:5])
            2'b00: val2 = rm_f << sh_amt;
            2'b01: val2 = rm_f >> sh_amt;
            2'b10: val2 = $unsigned($signed(rm_f) >>> sh_amt);
            default: begin
               rot_tmp = {rm_f, rm_f} >> sh_amt;
               val2    = rot_tmp[DW-1:0];
            end
         endcase
      end
   end

   logic [3:0]    status_q, status_d;
   logic [DW-1:0] result;
   logic [DW-1:0] add_b;
   logic [DW:0]   sum;
   logic          cin;
   logic          arith;
   logic          c_new, v_new;

   // Subtraction is op1 + ~Val2 + carry-in, so C=1 means no borrow.
   always_comb begin
      result = '0;
      add_b  = val2;
      cin    = 1'b0;
      arith  = 1'b0;
      case (exe_cmd)
         4'b0001: result = val2;
         4'b1001: result = ~val2;
         4'b0010: arith  = 1'b1;
         4'b0011: begin arith = 1'b1; cin = status_q[1]; end
         4'b0100: begin arith = 1'b1; add_b = ~val2; cin = 1'b1; end
         4'b0101: begin arith = 1'b1; add_b = ~val2; cin = status_q[1]; end
         4'b0110: result = op1 & val2;
         4'b0111: result = op1 | val2;
         4'b1000: result = op1 ^ val2;
         default: result = '0;
      endcase
      sum   = {1'b0, op1} + {1'b0, add_b} + {{DW{1'b0}}, cin};
      c_new = status_q[1];
      v_new = status_q[0];
      if (arith) begin
         result = sum[DW-1:0];
         c_new  = sum[DW];
         v_new  = (op1[DW-1] == add_b[DW-1]) && (result[DW-1] != op1[DW-1]);
      end
      if (s_in && !freeze) begin
         status_d = {result[DW-1], (result == '0), c_new, v_new};
      end else begin
         status_d = status_q;
      end
   end

   logic          wb_en_q, wb_en_d;
   logic          mem_r_en_q, mem_r_en_d;
   logic          mem_w_en_q, mem_w_en_d;
   logic [DW-1:0] alu_result_q, alu_result_d;
   logic [DW-1:0] val_Rm_out_q, val_Rm_out_d;
   logic [RW-1:0] dest_q, dest_d;

   always_comb begin
      if (freeze) begin
         wb_en_d      = wb_en_q;
         mem_r_en_d   = mem_r_en_q;
         mem_w_en_d   = mem_w_en_q;
         alu_result_d = alu_result_q;
         val_Rm_out_d = val_Rm_out_q;
         dest_d       = dest_q;
      end else begin
         wb_en_d      = wb_en_in;
         mem_r_en_d   = mem_r_en_in;
         mem_w_en_d   = mem_w_en_in;
         alu_result_d = result;
         val_Rm_out_d = rm_f;
         dest_d       = dest_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_q      <= 1'b0;
         mem_r_en_q   <= 1'b0;
         mem_w_en_q   <= 1'b0;
         alu_result_q <= '0;
         val_Rm_out_q <= '0;
         dest_q       <= '0;
         status_q     <= 4'b0000;
      end else begin
         wb_en_q      <= wb_en_d;
         mem_r_en_q   <= mem_r_en_d;
         mem_w_en_q   <= mem_w_en_d;
         alu_result_q <= alu_result_d;
         val_Rm_out_q <= val_Rm_out_d;
         dest_q       <= dest_d;
         status_q     <= status_d;
      end
   end

   assign wb_en      = wb_en_q;
   assign mem_r_en   = mem_r_en_q;
   assign mem_w_en   = mem_w_en_q;
   assign alu_result = alu_result_q;
   assign val_Rm_out = val_Rm_out_q;
   assign dest       = dest_q;
   assign status     = status_q;

   // Branch path is combinational; the upstream stages stall on the same freeze.
   assign branch_taken   = b_in;
   assign branch_address = pc_in + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed-vector bench for exe_stage_pipe: the driver pushes hand-computed
// expected register contents, a negedge monitor pops and compares them.
module tb_exe_stage_pipe;

   localparam int EW = 75;  // {wb,mr,mw}, alu_result, val_Rm_out, dest, status

   logic        clk;
   logic        rst;
   logic        freeze;
   logic [3:0]  exe_cmd;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [31:0] pc_in, val_Rn, val_Rm, fwd_mem_val, fwd_wb_val;
   logic [3:0]  dest_in;
   logic [1:0]  sel_src1, sel_src2;
   logic        wb_en, mem_r_en, mem_w_en, branch_taken;
   logic [31:0] alu_result, val_Rm_out, branch_address;
   logic [3:0]  dest, status;

   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   logic          issue;
   logic          pend;
   int            checks;
   int            errors;

   exe_stage_pipe #(.DW(32), .RW(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .s_in(s_in), .b_in(b_in), .imm(imm), .shift_operand(shift_operand),
      .signed_imm_24(signed_imm_24), .pc_in(pc_in), .val_Rn(val_Rn), .val_Rm(val_Rm),
      .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
      .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_result(alu_result), .val_Rm_out(val_Rm_out), .dest(dest), .status(status),
      .branch_taken(branch_taken), .branch_address(branch_address)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) pend <= issue;

   // monitor
   always @(negedge clk) begin
      if (pend === 1'b1) begin
         logic [EW-1:0] got;
         logic [EW-1:0] exp;
         string nm;
         got = {wb_en, mem_r_en, mem_w_en, alu_result, val_Rm_out, dest, status};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: output presented with empty expected queue, got %h", got);
         end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL %s: got en=%b alu=%h rm=%h dest=%h st=%b, exp en=%b alu=%h rm=%h dest=%h st=%b",
                        nm, got[74:72], got[71:40], got[39:8], got[7:4], got[3:0],
                        exp[74:72], exp[71:40], exp[39:8], exp[7:4], exp[3:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic cyc(input string nm, input logic [2:0] en, input logic [31:0] alu,
                      input logic [31:0] rm, input logic [3:0] d, input logic [3:0] st);
      exp_q.push_back({en, alu, rm, d, st});
      name_q.push_back(nm);
      issue = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_branch(input string nm, input logic exp_taken, input logic [31:0] exp_addr);
      #1;
      checks++;
      if (branch_taken !== exp_taken || branch_address !== exp_addr) begin
         errors++;
         $display("FAIL %s: got taken=%b addr=%h, exp taken=%b addr=%h",
                  nm, branch_taken, branch_address, exp_taken, exp_addr);
      end
   endtask

   task automatic clear_inputs();
      exe_cmd = 4'd0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; b_in = 0;
      imm = 0; shift_operand = '0; signed_imm_24 = '0; pc_in = '0; val_Rn = '0; val_Rm = '0;
      dest_in = '0; sel_src1 = 2'd0; sel_src2 = 2'd0; fwd_mem_val = '0; fwd_wb_val = '0;
   endtask

   initial begin
      checks = 0; errors = 0; issue = 1'b0;
      rst = 1'b1; freeze = 1'b1;
      clear_inputs();
      @(negedge clk);
      // reset wins over freeze, random inputs ignored
      exe_cmd = 4'($urandom_range(0, 15)); wb_en_in = 1'($urandom_range(0, 1));
      mem_r_en_in = 1'($urandom_range(0, 1)); mem_w_en_in = 1'($urandom_range(0, 1));
      s_in = 1'b1; imm = 1'($urandom_range(0, 1)); shift_operand = 12'($urandom_range(0, 4095));
      val_Rn = $urandom; val_Rm = $urandom; dest_in = 4'($urandom_range(0, 15));
      cyc("reset", 3'b000, 32'h0, 32'h0, 4'h0, 4'b0000);

      rst = 1'b0; freeze = 1'b0; clear_inputs();
      val_Rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; exe_cmd = 4'b0010;
      s_in = 1; wb_en_in = 1; dest_in = 4'd3;
      cyc("add_s_overflow", 3'b100, 32'h8000_0000, 32'h0, 4'd3, 4'b1001);

      clear_inputs(); imm = 1; shift_operand = 12'h4FF; exe_cmd = 4'b0001;
      wb_en_in = 1; dest_in = 4'd4; val_Rm = 32'h1234;
      cyc("mov_rot_imm", 3'b100, 32'hFF00_0000, 32'h1234, 4'd4, 4'b1001);

      clear_inputs(); val_Rm = 32'h8000_0000; shift_operand = 12'h0C0; exe_cmd = 4'b0001;
      s_in = 1; wb_en_in = 1; dest_in = 4'd5;
      cyc("mov_asr1", 3'b100, 32'hC000_0000, 32'h8000_0000, 4'd5, 4'b1001);

      clear_inputs(); val_Rm = 32'hF0; shift_operand = 12'h220; exe_cmd = 4'b0001;
      wb_en_in = 1; dest_in = 4'd5;
      cyc("mov_lsr4", 3'b100, 32'h0000_000F, 32'hF0, 4'd5, 4'b1001);

      clear_inputs(); val_Rn = 32'hFFFF_FFFF; val_Rm = 32'h0F; shift_operand = 12'h260;
      exe_cmd = 4'b1000; s_in = 1; wb_en_in = 1; dest_in = 4'd6;
      cyc("eor_ror4", 3'b100, 32'h0FFF_FFFF, 32'h0F, 4'd6, 4'b0001);

      clear_inputs(); val_Rn = 32'd5; imm = 1; shift_operand = 12'h005; exe_cmd = 4'b0100; s_in = 1;
      cyc("cmp_equal", 3'b000, 32'h0, 32'h0, 4'd0, 4'b0110);

      clear_inputs(); val_Rn = 32'd1; imm = 1; shift_operand = 12'h001; exe_cmd = 4'b0011;
      s_in = 1; wb_en_in = 1; dest_in = 4'd1;
      cyc("adc_carry_in", 3'b100, 32'd3, 32'h0, 4'd1, 4'b0000);

      clear_inputs(); val_Rn = 32'd10; imm = 1; shift_operand = 12'h003; exe_cmd = 4'b0101;
      s_in = 1; wb_en_in = 1; dest_in = 4'd2;
      cyc("sbc_borrow", 3'b100, 32'd6, 32'h0, 4'd2, 4'b0010);

      clear_inputs(); val_Rn = 32'hFF00_FF00; imm = 1; shift_operand = 12'h0F0; exe_cmd = 4'b0110;
      s_in = 1;
      cyc("tst_zero", 3'b000, 32'h0, 32'h0, 4'd0, 4'b0110);

      clear_inputs(); val_Rn = 32'h8000_0000; imm = 1; shift_operand = 12'h001; exe_cmd = 4'b0111;
      s_in = 1; wb_en_in = 1; dest_in = 4'd8;
      cyc("orr_neg", 3'b100, 32'h8000_0001, 32'h0, 4'd8, 4'b1010);

      clear_inputs(); val_Rn = 32'h1234_5678; imm = 1; shift_operand = 12'h0AA; exe_cmd = 4'b1111;
      s_in = 1; wb_en_in = 1; dest_in = 4'd8;
      cyc("undef_opcode", 3'b100, 32'h0, 32'h0, 4'd8, 4'b0110);

      clear_inputs(); imm = 1; shift_operand = 12'h000; exe_cmd = 4'b1001; wb_en_in = 1; dest_in = 4'd9;
      cyc("mvn_zero", 3'b100, 32'hFFFF_FFFF, 32'h0, 4'd9, 4'b0110);

      clear_inputs(); sel_src1 = 2'd3; sel_src2 = 2'd3; val_Rn = 32'd2; val_Rm = 32'd9;
      fwd_mem_val = 32'hAAAA; fwd_wb_val = 32'hBBBB; exe_cmd = 4'b0010; wb_en_in = 1; dest_in = 4'd10;
      cyc("add_sel3_regfile", 3'b100, 32'd11, 32'd9, 4'd10, 4'b0110);

      clear_inputs(); sel_src1 = 2'd2; sel_src2 = 2'd1; fwd_wb_val = 32'h100; fwd_mem_val = 32'h55;
      val_Rn = 32'hDEAD; val_Rm = 32'h1111; mem_r_en_in = 1; wb_en_in = 1; shift_operand = 12'hFFF;
      exe_cmd = 4'b0010; dest_in = 4'd11;
      cyc("ldr_fwd_wb", 3'b110, 32'h0000_10FF, 32'h55, 4'd11, 4'b0110);

      clear_inputs(); sel_src1 = 2'd1; fwd_mem_val = 32'h10; val_Rn = 32'hDEAD;
      sel_src2 = 2'd2; fwd_wb_val = 32'hCAFE_BABE; val_Rm = 32'h1111; mem_w_en_in = 1;
      shift_operand = 12'h004; exe_cmd = 4'b0010; dest_in = 4'd7;
      cyc("str_fwd_mem", 3'b001, 32'h14, 32'hCAFE_BABE, 4'd7, 4'b0110);

      for (int i = 0; i < 3; i++) begin
         freeze = 1'b1; clear_inputs();
         s_in = 1; exe_cmd = 4'b0001; imm = 1; shift_operand = 12'h0FF + 12'(i);
         wb_en_in = 1; dest_in = 4'd9; val_Rm = 32'h2222 + 32'(i);
         cyc("freeze_hold", 3'b001, 32'h14, 32'hCAFE_BABE, 4'd7, 4'b0110);
      end

      freeze = 1'b0; clear_inputs(); s_in = 1; exe_cmd = 4'b0001; imm = 1; shift_operand = 12'h0FF;
      wb_en_in = 1; dest_in = 4'd9; val_Rm = 32'h2222;
      pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE; b_in = 1;
      check_branch("branch_back", 1'b1, 32'h0000_00F8);
      cyc("unfreeze_mov", 3'b100, 32'h0000_00FF, 32'h2222, 4'd9, 4'b0010);

      clear_inputs(); pc_in = 32'h1000; signed_imm_24 = 24'h000010; b_in = 0;
      check_branch("branch_fwd_not_taken", 1'b0, 32'h0000_1040);
      freeze = 1'b1; b_in = 1; pc_in = 32'hFFFF_FFFC; signed_imm_24 = 24'h000001;
      check_branch("branch_wrap_frozen", 1'b1, 32'h0000_0000);
      cyc("freeze_after_branch", 3'b100, 32'h0000_00FF, 32'h2222, 4'd9, 4'b0010);

      issue = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries never observed, exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, exp finish before 100000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
